// File: rtl/hw_dispatch_sched.sv
// Round-robin push scheduler for the dispatch FIFO: config+value write sequencing and slot tracking.
// Optional HW_DISPATCH_SCHED_SKIP_CONF_EN: omit the config write when the team mask repeats.
module hw_dispatch_sched #(
  parameter int unsigned NB_CORES   = 4,
  parameter int unsigned NB_MASTERS = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NB_MASTERS-1:0]          push_req_i,
  input  logic [NB_MASTERS*32-1:0]       push_data_i,
  input  logic [NB_MASTERS*NB_CORES-1:0] push_mask_i,
  output logic [NB_MASTERS-1:0]          push_gnt_o,
  output logic [NB_MASTERS-1:0]          push_err_o,
  input  logic [NB_CORES-1:0]            cons_i,
  output logic                           disp_w_req_o,
  output logic [31:0]                    disp_w_data_o,
  output logic [1:0]                     disp_reg_sel_o,
  output logic                           full_o,
  output logic [$clog2(FIFO_DEPTH):0]    count_o,
  output logic                           spurious_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MST_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, CONF, VAL} state_e;

  state_e              state_q, state_d;
  logic [MST_W-1:0]    mst_q, mst_d, rr_q, rr_d;
  logic [31:0]         data_q, data_d;
  logic [NB_CORES-1:0] mask_q, mask_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d, hptr_q, hptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NB_CORES-1:0] pend_q [FIFO_DEPTH];
  logic [NB_CORES-1:0] pend_d [FIFO_DEPTH];
  logic                spur_q, spur_d;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
  logic [NB_CORES-1:0] last_mask_q, last_mask_d;
  logic                last_valid_q, last_valid_d;
`endif

  logic                any_req;
  logic [MST_W-1:0]    win, idx;
  logic [NB_CORES-1:0] win_mask;
  logic                val_wr, retire, hit;
  logic [PTR_W-1:0]    slot;

  assign full_o     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign count_o    = cnt_q;
  assign spurious_o = spur_q;
  assign val_wr     = (state_q == VAL);

  // Round-robin pick: lowest offset from rr_q wins, so scan offsets downward.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = int'(NB_MASTERS) - 1; k >= 0; k--) begin
      idx = MST_W'((32'(rr_q) + 32'(k)) % NB_MASTERS);
      if (push_req_i[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
    win_mask = push_mask_i[32'(win)*NB_CORES +: NB_CORES];
  end

  // Push sequencing FSM.
  always_comb begin
    state_d        = state_q;
    mst_d          = mst_q;
    rr_d           = rr_q;
    data_d         = data_q;
    mask_d         = mask_q;
    push_gnt_o     = '0;
    push_err_o     = '0;
    disp_w_req_o   = 1'b0;
    disp_w_data_o  = '0;
    disp_reg_sel_o = 2'd0;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
    last_mask_d    = last_mask_q;
    last_valid_d   = last_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req && !full_o) begin
          if (win_mask == '0) begin
            push_gnt_o[win] = 1'b1;
            push_err_o[win] = 1'b1;
          end else begin
            mst_d   = win;
            data_d  = push_data_i[32'(win)*32 +: 32];
            mask_d  = win_mask;
            state_d = CONF;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
            if (last_valid_q && (win_mask == last_mask_q)) state_d = VAL;
`endif
          end
        end
      end
      CONF: begin
        disp_w_req_o   = 1'b1;
        disp_reg_sel_o = 2'd1;
        disp_w_data_o  = 32'(mask_q);
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
        last_mask_d    = mask_q;
        last_valid_d   = 1'b1;
`endif
        state_d        = VAL;
      end
      VAL: begin
        disp_w_req_o      = 1'b1;
        disp_reg_sel_o    = 2'd0;
        disp_w_data_o     = data_q;
        push_gnt_o[mst_q] = 1'b1;
        rr_d              = MST_W'((32'(mst_q) + 32'd1) % NB_MASTERS);
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot tracker: each consumed bit clears the oldest occupied slot still waiting on that core.
  always_comb begin
    pend_d = pend_q;
    spur_d = 1'b0;
    hptr_d = hptr_q;
    wptr_d = wptr_q;
    hit    = 1'b0;
    slot   = '0;
    for (int i = 0; i < int'(NB_CORES); i++) begin
      if (cons_i[i]) begin
        hit = 1'b0;
        for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
          slot = PTR_W'(32'(hptr_q) + 32'(k));
          if (!hit && (CNT_W'(k) < cnt_q) && pend_q[slot][i]) begin
            pend_d[slot][i] = 1'b0;
            hit             = 1'b1;
          end
        end
        if (!hit) spur_d = 1'b1;
      end
    end
    retire = (cnt_q != '0) && (pend_q[hptr_q] == '0);
    if (retire) hptr_d = hptr_q + 1'b1;
    if (val_wr) begin
      pend_d[wptr_q] = mask_q;
      wptr_d         = wptr_q + 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(val_wr) - CNT_W'(retire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mst_q   <= '0;
      rr_q    <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wptr_q  <= '0;
      hptr_q  <= '0;
      cnt_q   <= '0;
      spur_q  <= 1'b0;
      for (int k = 0; k < int'(FIFO_DEPTH); k++) pend_q[k] <= '0;
    end else begin
      state_q <= state_d;
      mst_q   <= mst_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wptr_q  <= wptr_d;
      hptr_q  <= hptr_d;
      cnt_q   <= cnt_d;
      spur_q  <= spur_d;
      pend_q  <= pend_d;
    end
  end

`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_mask_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_mask_q  <= last_mask_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_hw_dispatch_sched.sv
// Scoreboard bench for hw_dispatch_sched: queue-based reference model, directed and random pushes/consumes.
module tb_hw_dispatch_sched;
  localparam int unsigned NC = 4;
  localparam int unsigned NM = 2;
  localparam int unsigned FD = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NM-1:0]     push_req_i;
  logic [NM*32-1:0]  push_data_i;
  logic [NM*NC-1:0]  push_mask_i;
  logic [NM-1:0]     push_gnt_o, push_err_o;
  logic [NC-1:0]     cons_i;
  logic              disp_w_req_o;
  logic [31:0]       disp_w_data_o;
  logic [1:0]        disp_reg_sel_o;
  logic              full_o;
  logic [2:0]        count_o;
  logic              spurious_o;

  hw_dispatch_sched #(.NB_CORES(NC), .NB_MASTERS(NM), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_req_i(push_req_i), .push_data_i(push_data_i),
    .push_mask_i(push_mask_i), .push_gnt_o(push_gnt_o), .push_err_o(push_err_o), .cons_i(cons_i),
    .disp_w_req_o(disp_w_req_o), .disp_w_data_o(disp_w_data_o), .disp_reg_sel_o(disp_reg_sel_o),
    .full_o(full_o), .count_o(count_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [1:0] sel; logic [31:0] data; } wr_t;
  typedef struct packed { logic [NM-1:0] gnt; logic [NM-1:0] err; } gnt_t;
  wr_t  exp_wr[$];
  gnt_t exp_gnt[$];
  logic exp_spur[$];

  // Reference model: occupied slots as a queue of still-pending core masks, oldest first.
  logic [NC-1:0] mq[$];
  int            rr_m = 0;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
  logic          lv_m = 1'b0;
  logic [NC-1:0] lm_m = '0;
`endif

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_push(int m, logic [31:0] d, logic [NC-1:0] mk);
    gnt_t g;
    wr_t  w;
    logic conf;
    g.gnt = '0; g.err = '0; g.gnt[m] = 1'b1;
    if (mk == '0) begin
      g.err[m] = 1'b1;
      exp_gnt.push_back(g);
      return 1;
    end
    conf = 1'b1;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
    if (lv_m && mk == lm_m) conf = 1'b0;
    lv_m = 1'b1;
    lm_m = mk;
`endif
    if (conf) begin
      w.sel = 2'd1; w.data = 32'(mk);
      exp_wr.push_back(w);
    end
    w.sel = 2'd0; w.data = d;
    exp_wr.push_back(w);
    exp_gnt.push_back(g);
    mq.push_back(mk);
    rr_m = (m + 1) % NM;
    return conf ? 3 : 2;
  endfunction

  function automatic logic model_cons(logic [NC-1:0] c);
    logic          sp;
    logic          found;
    logic [NC-1:0] t;
    sp = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (c[i]) begin
        found = 1'b0;
        for (int j = 0; j < mq.size(); j++) begin
          if (!found && mq[j][i]) begin
            t = mq[j]; t[i] = 1'b0; mq[j] = t;
            found = 1'b1;
          end
        end
        if (!found) sp = 1'b1;
      end
    end
    while (mq.size() > 0 && mq[0] == '0) void'(mq.pop_front());
    return sp;
  endfunction

  // Monitor: every DUT write, grant and consume response is matched against the queues.
  wr_t  mon_w;
  gnt_t mon_g;
  logic cons_seen = 1'b0;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (disp_w_req_o) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got sel=%0d data=%0h expected no write", disp_reg_sel_o, disp_w_data_o);
        end else begin
          mon_w = exp_wr.pop_front();
          check("write_sel", 32'(disp_reg_sel_o), 32'(mon_w.sel));
          check("write_data", disp_w_data_o, mon_w.data);
        end
      end
      if (push_gnt_o != '0) begin
        if (exp_gnt.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_grant: got gnt=%0b expected none", push_gnt_o);
        end else begin
          mon_g = exp_gnt.pop_front();
          check("grant_vec", 32'(push_gnt_o), 32'(mon_g.gnt));
          check("error_vec", 32'(push_err_o), 32'(mon_g.err));
        end
      end
      if (cons_seen) begin
        if (exp_spur.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_queue: got consume response with no expectation");
        end else check("spurious", 32'(spurious_o), 32'(exp_spur.pop_front()));
      end else if (spurious_o) begin
        total++; bad++;
        $display("FAIL spurious_unexpected: got 1 expected 0");
      end
      cons_seen = (cons_i != '0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive(int m, logic [31:0] d, logic [NC-1:0] mk);
    push_req_i[m] = 1'b1;
    push_data_i[m*32 +: 32] = d;
    push_mask_i[m*NC +: NC] = mk;
  endtask

  task automatic wait_gnt(int m, output int lat);
    lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk_i);
      if (push_gnt_o[m]) lat = c;
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL grant_timeout m%0d: got no grant expected grant", m);
    end
    @(posedge clk_i); #1;
    push_req_i[m] = 1'b0;
  endtask

  task automatic do_push(int m, logic [31:0] d, logic [NC-1:0] mk);
    int el;
    int lat;
    el = model_push(m, d, mk);
    drive(m, d, mk);
    wait_gnt(m, lat);
    check("grant_latency", 32'(lat), 32'(el));
  endtask

  task automatic do_cons(logic [NC-1:0] c);
    exp_spur.push_back(model_cons(c));
    cons_i = c;
    tick(1);
    cons_i = '0;
  endtask

  task automatic check_count(string n);
    check({n, "_count"}, 32'(count_o), 32'(mq.size()));
    check({n, "_full"}, 32'(full_o), (mq.size() == FD) ? 32'd1 : 32'd0);
  endtask

  task automatic drain();
    while (mq.size() > 0) begin
      do_cons(mq[0]);
      tick(FD + 1);
    end
  endtask

  task automatic do_reset();
    push_req_i = '0;
    cons_i     = '0;
    rst_ni     = 1'b0;
    tick(2);
    mq.delete();
    rr_m = 0;
`ifdef HW_DISPATCH_SCHED_SKIP_CONF_EN
    lv_m = 1'b0;
`endif
    rst_ni = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    int            got;
    int            n;
    int            m;
    logic [NC-1:0] mk;
    logic [NC-1:0] last_mk;
    push_req_i  = '0;
    push_data_i = '0;
    push_mask_i = '0;
    cons_i      = '0;
    last_mk     = 4'b0101;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_wreq", 32'(disp_w_req_o), 32'd0);
    check("rst_gnt", 32'(push_gnt_o), 32'd0);
    check("rst_spurious", 32'(spurious_o), 32'd0);
    rst_ni = 1'b1;
    tick(1);

    // First push: config write then value write, grant on cycle 3.
    do_push(0, 32'hCAFE, 4'b0011);
    tick(1);
    check_count("first_push");
    drain();
    check_count("drained");

    // Two masters requesting continuously alternate from m0, filling the FIFO.
    do_reset();
    for (int k = 0; k < 4; k++) void'(model_push(rr_m, (rr_m == 0) ? 32'hA0 : 32'hB1, (rr_m == 0) ? 4'b0001 : 4'b0010));
    drive(0, 32'hA0, 4'b0001);
    drive(1, 32'hB1, 4'b0010);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk_i);
      if (push_gnt_o != '0) n++;
    end
    @(posedge clk_i); #1;
    push_req_i = '0;
    check("rr_grants", 32'(n), 32'd4);
    tick(1);
    check_count("filled");

    // Full: a fifth request waits until a slot retires.
    drive(0, 32'hD00D, 4'b0100);
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (push_gnt_o != '0) got = 1;
    end
    @(posedge clk_i); #1;
    check("full_hold_no_grant", 32'(got), 32'd0);
    do_cons(4'b0001);
    void'(model_push(0, 32'hD00D, 4'b0100));
    wait_gnt(0, lat);
    tick(1);
    check_count("after_full");
    drain();

    // Zero mask is rejected in the accept cycle, count unchanged.
    do_push(1, 32'h55, 4'b1000);
    do_push(1, 32'h77, 4'b0000);
    tick(1);
    check_count("zero_mask");
    drain();

    // Two-core slot retires one cycle after its last ack; consume on empty is spurious.
    do_push(0, 32'h66, 4'b0110);
    tick(1);
    do_cons(4'b0010);
    tick(FD + 1);
    check_count("partial_ack");
    do_cons(4'b0100);
    check("retire_not_yet", 32'(count_o), 32'd1);
    tick(1);
    check("retire_next_cycle", 32'(count_o), 32'd0);
    do_cons(4'b1000);
    tick(2);

    // Repeated mask: with the skip feature the second push omits its config write.
    do_reset();
    do_push(0, 32'h1111, 4'b1111);
    do_push(1, 32'h2222, 4'b1111);
    drain();

    // Random pushes and consumes against the model.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        if (mq.size() == FD) begin
          do_cons(mq[0]);
          tick(FD + 1);
        end
        m  = int'($urandom_range(0, NM - 1));
        mk = ($urandom_range(0, 3) == 0) ? last_mk : NC'($urandom);
        last_mk = mk;
        do_push(m, $urandom, mk);
      end else begin
        do_cons(NC'($urandom_range(1, 15)));
        tick(FD + 1);
      end
      check_count("random");
    end
    drain();
    tick(3);
    check("left_writes", 32'(exp_wr.size()), 32'd0);
    check("left_grants", 32'(exp_gnt.size()), 32'd0);
    check("left_spurious", 32'(exp_spur.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
